i2s_slave_rx: RTL and testbench

- Receive-side counterpart of our I2S master/PISO audio path, for boards where the codec is clock master.
- Accepts externally generated BCK, LRCK and serial data, oversamples them with iCLK_18_4, and deserializes MSB-first words into left/right 16-bit samples.
- Presents each complete stereo pair with a one-cycle strobe.
- Feeds the same sample consumers as the linein path, and reports framing errors and link lock.

---
 rtl/i2s_slave_rx.sv | 209 ++++++++++++++++++++
 tb/tb_i2s_slave_rx.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_slave_rx.sv
// Slave-mode I2S / left-justified receiver: the codec drives BCK and LRCK, we oversample
// them with iCLK_18_4 and deliver each complete left/right pair with a one-cycle strobe.
module i2s_slave_rx #(
   parameter int DATA_WIDTH = 16,
   parameter int SLOT_BITS  = 16,
   parameter int I2S_DELAY  = 1,
   parameter int TIMEOUT    = 64
) (
   input  logic                  iCLK_18_4,
   input  logic                  iRST_N,
   input  logic                  iAUD_BCK,
   input  logic                  iAUD_LRCK,
   input  logic                  iAUD_DAT,
   output logic [DATA_WIDTH-1:0] oLEFT,
   output logic [DATA_WIDTH-1:0] oRIGHT,
   output logic                  oVALID,
   output logic                  oFRAME_ERR,
   output logic                  oLOCK
);

   typedef enum logic {HUNT, RUN} state_t;

   localparam int         TO_W    = $clog2(TIMEOUT + 1);
   localparam logic [5:0] DW6     = 6'(DATA_WIDTH);
   localparam logic [5:0] SLOT6   = 6'(SLOT_BITS);
   localparam logic [5:0] CNT_MAX = 6'd63;

   logic [1:0] bck_sync;
   logic [1:0] lrck_sync;
   logic [1:0] dat_sync;
   logic       bck_d2;
   logic       rise_q;
   logic       lrck_q;
   logic       dat_q;

   // LRCK and DAT are registered alongside the detected edge so all three stay aligned.
   // NOTE: sequential state is always written with <=, so every flop samples pre-edge values.
   always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
      if (!iRST_N) begin
         bck_sync  <= '0;
         lrck_sync <= '0;
         dat_sync  <= '0;
         bck_d2    <= 1'b0;
         rise_q    <= 1'b0;
         lrck_q    <= 1'b0;
         dat_q     <= 1'b0;
      end else begin
         bck_sync  <= {bck_sync[0], iAUD_BCK};
         lrck_sync <= {lrck_sync[0], iAUD_LRCK};
         dat_sync  <= {dat_sync[0], iAUD_DAT};
         bck_d2    <= bck_sync[1];
         rise_q    <= bck_sync[1] & ~bck_d2;
         lrck_q    <= lrck_sync[1];
         dat_q     <= dat_sync[1];
      end
   end

   logic [TO_W-1:0] to_cnt;
   logic            timeout;

   // Fires once when the silence reaches TIMEOUT; a rise in the same cycle wins.
   assign timeout = ~rise_q && (to_cnt == TO_W'(TIMEOUT - 1));

   always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
      if (!iRST_N)
         to_cnt <= '0;
      else if (rise_q)
         to_cnt <= '0;
      else if (to_cnt != TO_W'(TIMEOUT))
         to_cnt <= to_cnt + TO_W'(1);
   end

   logic lrck_prev;
   logic prev_ok;
   logic boundary;

   // prev_ok keeps the first rise after reset or a lost link from posing as a boundary.
   assign boundary = rise_q & prev_ok & (lrck_q ^ lrck_prev);

   state_t state;
   state_t state_nxt;

   always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
      if (!iRST_N)
         state <= HUNT;
      else
         state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         HUNT:    if (boundary) state_nxt = RUN;
         RUN:     if (timeout)  state_nxt = HUNT;
         default: state_nxt = HUNT;
      endcase
   end

   logic take_bit;
   logic close_slot;
   logic open_slot;
   logic first_bit;

   always_comb begin
      take_bit   = 1'b0;
      close_slot = 1'b0;
      open_slot  = boundary;
      first_bit  = boundary && (I2S_DELAY == 0);
      if (state == RUN && rise_q) begin
         take_bit   = ~boundary | (I2S_DELAY != 0);
         close_slot = boundary;
      end
   end

   logic [5:0]            bitcnt;
   logic [5:0]            cnt_app;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] sh_app;
   logic [DATA_WIDTH-1:0] word;

   // Slot contents after the current bit is appended; short slots are left-aligned on close.
   always_comb begin
      cnt_app = bitcnt;
      sh_app  = shreg;
      if (take_bit) begin
         if (bitcnt < DW6)
            sh_app = {shreg[DATA_WIDTH-2:0], dat_q};
         if (bitcnt != CNT_MAX)
            cnt_app = bitcnt + 6'd1;
      end
      word = (cnt_app < DW6) ? (sh_app << (DW6 - cnt_app)) : sh_app;
   end

   logic                  have_left;
   logic                  left_err;
   logic [DATA_WIDTH-1:0] left_hold;
   logic                  slot_err;
   logic                  close_left;
   logic                  close_right;
   logic                  valid_nxt;
   logic                  ferr_nxt;

   always_comb begin
      slot_err    = (cnt_app != SLOT6);
      close_left  = close_slot & ~lrck_prev;
      close_right = close_slot & lrck_prev;
      valid_nxt   = close_right & have_left;
      ferr_nxt    = (close_slot & slot_err) | (close_right & ~have_left);
   end

   always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
      if (!iRST_N) begin
         bitcnt     <= '0;
         shreg      <= '0;
         lrck_prev  <= 1'b0;
         prev_ok    <= 1'b0;
         have_left  <= 1'b0;
         left_err   <= 1'b0;
         left_hold  <= '0;
         oLEFT      <= '0;
         oRIGHT     <= '0;
         oVALID     <= 1'b0;
         oFRAME_ERR <= 1'b0;
         oLOCK      <= 1'b0;
      end else begin
         oVALID     <= valid_nxt;
         oFRAME_ERR <= ferr_nxt;

         if (timeout) begin
            bitcnt    <= '0;
            shreg     <= '0;
            prev_ok   <= 1'b0;
            have_left <= 1'b0;
         end else if (rise_q) begin
            lrck_prev <= lrck_q;
            prev_ok   <= 1'b1;
            if (open_slot) begin
               bitcnt <= first_bit ? 6'd1 : 6'd0;
               shreg  <= first_bit ? DATA_WIDTH'(dat_q) : '0;
            end else if (take_bit) begin
               bitcnt <= cnt_app;
               shreg  <= sh_app;
            end
         end

         if (close_left) begin
            left_hold <= word;
            left_err  <= slot_err;
            have_left <= 1'b1;
         end

         // A right word without a preceding left slot is dropped.
         if (close_right) begin
            have_left <= 1'b0;
            if (have_left) begin
               oLEFT  <= left_hold;
               oRIGHT <= word;
            end
         end

         if (timeout | ferr_nxt)
            oLOCK <= 1'b0;
         else if (valid_nxt & ~left_err)
            oLOCK <= 1'b1;
      end
   end

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Drives codec-style BCK/LRCK/DAT streams into three receiver configurations and checks
// every output against a slot-level model of the same streams.
module tb_i2s_slave_rx;

   localparam int TIMEOUT = 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic bck   = 1'b0;
   logic lrck  = 1'b0;
   logic dat   = 1'b0;

   logic [15:0] left_o  [3];
   logic [15:0] right_o [3];
   logic        valid_o [3];
   logic        ferr_o  [3];
   logic        lock_o  [3];

   always #5 clk = ~clk;

   i2s_slave_rx #(.DATA_WIDTH(16), .SLOT_BITS(16), .I2S_DELAY(1), .TIMEOUT(TIMEOUT)) dut_std (
      .iCLK_18_4(clk), .iRST_N(rst_n), .iAUD_BCK(bck), .iAUD_LRCK(lrck), .iAUD_DAT(dat),
      .oLEFT(left_o[0]), .oRIGHT(right_o[0]), .oVALID(valid_o[0]), .oFRAME_ERR(ferr_o[0]),
      .oLOCK(lock_o[0]));

   i2s_slave_rx #(.DATA_WIDTH(16), .SLOT_BITS(32), .I2S_DELAY(1), .TIMEOUT(TIMEOUT)) dut_w32 (
      .iCLK_18_4(clk), .iRST_N(rst_n), .iAUD_BCK(bck), .iAUD_LRCK(lrck), .iAUD_DAT(dat),
      .oLEFT(left_o[1]), .oRIGHT(right_o[1]), .oVALID(valid_o[1]), .oFRAME_ERR(ferr_o[1]),
      .oLOCK(lock_o[1]));

   i2s_slave_rx #(.DATA_WIDTH(16), .SLOT_BITS(16), .I2S_DELAY(0), .TIMEOUT(TIMEOUT)) dut_lj (
      .iCLK_18_4(clk), .iRST_N(rst_n), .iAUD_BCK(bck), .iAUD_LRCK(lrck), .iAUD_DAT(dat),
      .oLEFT(left_o[2]), .oRIGHT(right_o[2]), .oVALID(valid_o[2]), .oFRAME_ERR(ferr_o[2]),
      .oLOCK(lock_o[2]));

   typedef struct {
      bit          v;
      bit          f;
      logic [15:0] l;
      logic [15:0] r;
      int          rise;
   } ev_t;

   ev_t         ev_q [3][$];
   int          slot_c [3] = '{16, 32, 16};
   int          dly_c  [3] = '{1, 1, 0};
   bit          exp_lock [3];
   logic [15:0] held_l [3];
   logic [15:0] held_r [3];
   bit          lr_q[$];
   bit          dt_q[$];
   logic [31:0] w_q[$];
   int          n_q[$];
   int          rc[$];
   int          cyc   = 0;
   int          tests = 0;
   int          fails = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) tick(1);
   endtask

   task automatic add_word(input logic [31:0] w, input int n);
      w_q.push_back(w);
      n_q.push_back(n);
   endtask

   // Per-rise LRCK/DAT stream: a short right-channel preamble, the queued words starting with
   // left, then a partial trailing slot. With delay the data runs one BCK behind LRCK.
   task automatic build(input bit delay, input int trail);
      bit db[$];
      int nw;
      bit ch;
      lr_q.delete();
      dt_q.delete();
      for (int i = 0; i < 3; i++) begin
         lr_q.push_back(1'b1);
         dt_q.push_back(1'($urandom));
      end
      if (delay) db.push_back(1'($urandom));
      nw = w_q.size();
      for (int j = 0; j < nw; j++) begin
         ch = j[0];
         for (int i = 0; i < n_q[j]; i++) begin
            lr_q.push_back(ch);
            db.push_back(w_q[j][n_q[j]-1-i]);
         end
      end
      ch = nw[0];
      for (int i = 0; i < trail; i++) lr_q.push_back(ch);
      for (int k = 0; k < lr_q.size() - 3; k++)
         dt_q.push_back(k < db.size() ? db[k] : 1'($urandom));
      w_q.delete();
      n_q.delete();
   endtask

   task automatic push_ev(input int c, input bit v, input bit f, input logic [15:0] l,
                          input logic [15:0] r, input int rise);
      ev_t e;
      e.v = v; e.f = f; e.l = l; e.r = r; e.rise = rise;
      ev_q[c].push_back(e);
   endtask

   // Slot view: runs of constant LRCK after the first one are slots; with delay a slot is its
   // run minus the first bit plus the first bit of the next run.
   task automatic run_model(input int base);
      int          b[$];
      bit          pend;
      bit          lerr;
      bit          err;
      logic [15:0] lw;
      logic [15:0] w;
      int          lo;
      int          n;
      for (int k = 1; k < lr_q.size(); k++)
         if (lr_q[k] != lr_q[k-1]) b.push_back(k);
      for (int c = 0; c < 3; c++) begin
         pend = 0;
         lerr = 0;
         lw   = '0;
         exp_lock[c] = 0;
         for (int j = 0; j + 1 < b.size(); j++) begin
            lo = b[j] + dly_c[c];
            n  = b[j+1] - b[j];
            w  = '0;
            for (int i = 0; i < 16 && i < n; i++) w[15-i] = dt_q[lo+i];
            err = (n != slot_c[c]);
            if (lr_q[b[j]] == 1'b0) begin
               lw   = w;
               lerr = err;
               pend = 1;
               if (err) begin
                  push_ev(c, 0, 1, '0, '0, base + b[j+1]);
                  exp_lock[c] = 0;
               end
            end else begin
               if (pend) begin
                  push_ev(c, 1, err, lw, w, base + b[j+1]);
                  exp_lock[c] = !(err || lerr);
               end else begin
                  push_ev(c, 0, 1, '0, '0, base + b[j+1]);
                  exp_lock[c] = 0;
               end
               pend = 0;
            end
         end
      end
   endtask

   task automatic drive();
      for (int k = 0; k < lr_q.size(); k++) begin
         tick(6);
         bck  = 1'b0;
         lrck = lr_q[k];
         dat  = dt_q[k];
         tick(6);
         bck = 1'b1;
         rc.push_back(cyc);
      end
      tick(6);
      bck = 1'b0;
   endtask

   task automatic gap_timeout();
      int r;
      r = rc[rc.size()-1];
      wait_cyc(r + 8);
      for (int c = 0; c < 3; c++) check($sformatf("cfg%0d_lock_end", c), lock_o[c], exp_lock[c]);
      wait_cyc(r + TIMEOUT - 4);
      for (int c = 0; c < 3; c++) check($sformatf("cfg%0d_lock_pre_to", c), lock_o[c], exp_lock[c]);
      wait_cyc(r + TIMEOUT + 12);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("cfg%0d_lock_post_to", c), lock_o[c], 0);
         exp_lock[c] = 0;
      end
      wait_cyc(r + 100);
   endtask

   task automatic reset_pulse();
      int r;
      r = rc[rc.size()-1];
      wait_cyc(r + 8);
      for (int c = 0; c < 3; c++) check($sformatf("cfg%0d_lock_pre_rst", c), lock_o[c], exp_lock[c]);
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         held_l[c]   = '0;
         held_r[c]   = '0;
         exp_lock[c] = 0;
      end
      #1;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("cfg%0d_rst_left", c), left_o[c], 0);
         check($sformatf("cfg%0d_rst_right", c), right_o[c], 0);
         check($sformatf("cfg%0d_rst_valid", c), valid_o[c], 0);
         check($sformatf("cfg%0d_rst_ferr", c), ferr_o[c], 0);
         check($sformatf("cfg%0d_rst_lock", c), lock_o[c], 0);
      end
      tick(1);
      rst_n = 1'b1;
      tick(20);
   endtask

   // Every pulse must match the next modelled event, 4 cycles after its closing BCK rise;
   // outside pulses the sample outputs must hold the last delivered pair.
   always @(negedge clk) begin
      ev_t e;
      for (int c = 0; c < 3; c++) begin
         if (valid_o[c] || ferr_o[c]) begin
            if (ev_q[c].size() == 0) begin
               check($sformatf("cfg%0d_unexpected_pulse", c), {valid_o[c], ferr_o[c]}, 0);
            end else begin
               e = ev_q[c].pop_front();
               check($sformatf("cfg%0d_pulse_vf", c), {valid_o[c], ferr_o[c]}, {e.v, e.f});
               check($sformatf("cfg%0d_latency", c), cyc - rc[e.rise], 4);
               if (e.v) begin
                  held_l[c] = e.l;
                  held_r[c] = e.r;
               end
            end
         end
         check($sformatf("cfg%0d_left", c), left_o[c], held_l[c]);
         check($sformatf("cfg%0d_right", c), right_o[c], held_r[c]);
      end
   end

   initial begin
      #3_000_000;
      fails++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      int nfr;
      int len;
      int mode;
      int nerr;
      for (int c = 0; c < 3; c++) begin
         held_l[c] = '0;
         held_r[c] = '0;
      end
      tick(3);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("cfg%0d_reset_left", c), left_o[c], 0);
         check($sformatf("cfg%0d_reset_lock", c), lock_o[c], 0);
      end
      rst_n = 1'b1;
      tick(5);

      // Standard I2S, three identical frames.
      for (int f = 0; f < 3; f++) begin
         add_word(32'h0000_A5C3, 16);
         add_word(32'h0000_0F0F, 16);
      end
      build(1, 4);
      run_model(rc.size());
      check("pin_std_count", ev_q[0].size(), 3);
      check("pin_std_left", ev_q[0][0].l, 16'hA5C3);
      check("pin_std_right", ev_q[0][2].r, 16'h0F0F);
      check("pin_std_noerr", ev_q[0][1].f, 0);
      check("pin_std_lock", exp_lock[0], 1);
      drive();
      gap_timeout();

      // 32-bit slots truncated to 16-bit samples.
      for (int f = 0; f < 2; f++) begin
         add_word(32'h8001_FFFF, 32);
         add_word(32'h7FFE_0000, 32);
      end
      build(1, 4);
      run_model(rc.size());
      check("pin_w32_count", ev_q[1].size(), 2);
      check("pin_w32_left", ev_q[1][0].l, 16'h8001);
      check("pin_w32_right", ev_q[1][0].r, 16'h7FFE);
      check("pin_w32_noerr", ev_q[1][1].f, 0);
      drive();
      gap_timeout();

      // Left-justified: MSB sits on the boundary rise.
      for (int f = 0; f < 2; f++) begin
         add_word(32'h0000_1234, 16);
         add_word(32'h0000_FEDC, 16);
      end
      build(0, 4);
      run_model(rc.size());
      check("pin_lj_left", ev_q[2][0].l, 16'h1234);
      check("pin_lj_right", ev_q[2][0].r, 16'hFEDC);
      check("pin_lj_lock", exp_lock[2], 1);
      drive();
      gap_timeout();

      // Short 15-bit left slot in the second frame, then clean frames re-lock.
      add_word(32'h0000_1111, 16);
      add_word(32'h0000_2222, 16);
      add_word(32'h0000_7FFF, 15);
      add_word(32'h0000_3333, 16);
      add_word(32'h0000_4444, 16);
      add_word(32'h0000_5555, 16);
      add_word(32'h0000_6666, 16);
      add_word(32'h0000_7777, 16);
      build(1, 4);
      run_model(rc.size());
      nerr = 0;
      foreach (ev_q[0][i]) nerr += int'(ev_q[0][i].f);
      check("pin_short_errs", nerr, 1);
      check("pin_short_word", ev_q[0][2].l, 16'hFFFE);
      check("pin_short_relock", exp_lock[0], 1);
      drive();
      gap_timeout();

      // BCK stops mid right slot.
      add_word(32'h0000_CAFE, 16);
      add_word(32'h0000_BEEF, 16);
      add_word(32'h0000_0BAD, 16);
      build(1, 8);
      run_model(rc.size());
      drive();
      gap_timeout();

      // Reset mid slot, then a full resync.
      for (int f = 0; f < 2; f++) begin
         add_word($urandom, 16);
         add_word($urandom, 16);
      end
      add_word($urandom, 16);
      build(1, 5);
      run_model(rc.size());
      drive();
      reset_pulse();
      for (int f = 0; f < 2; f++) begin
         add_word($urandom, 16);
         add_word($urandom, 16);
      end
      build(1, 3);
      run_model(rc.size());
      drive();
      gap_timeout();

      // Randomized sessions across all three slot formats with occasional bad lengths.
      for (int s = 0; s < 6; s++) begin
         mode = s % 3;
         nfr  = 2 + $urandom_range(0, 2);
         for (int w = 0; w < 2 * nfr; w++) begin
            len = (mode == 1) ? 32 : 16;
            if ($urandom_range(0, 7) == 0) len = len - 1 + 2 * $urandom_range(0, 1);
            add_word($urandom, len);
         end
         build(mode != 2, 2 + $urandom_range(0, 5));
         run_model(rc.size());
         drive();
         gap_timeout();
      end

      for (int c = 0; c < 3; c++) check($sformatf("cfg%0d_missing_events", c), ev_q[c].size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
